// File: rtl/bounce_scheduler.sv
// ---------------------------------------------------------------------------
// bounce_scheduler
//
// Frame-synchronous motion scheduler for N_OBJ bouncing objects. All objects
// share one position-update datapath, and each accepted pass walks the slots
// one per clock. A finished pass is copied into a snapshot bank that the
// renderer reads through a registered, indexed port. The renderer never sees
// the working values, so a frame can never show a half-updated scene.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse at frame start
//   enable       allows new passes; sampled together with frame_start
//   rd_idx       snapshot read index
//   rd_x, rd_y   registered snapshot centre of slot rd_idx (0 if out of range)
//   busy         update pass in progress (UPDATE or PUBLISH)
//   update_done  one-cycle pulse in the PUBLISH cycle
//   overrun      frame_start seen while busy (combinational, same cycle)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | wait for frame_start && enable; divide by FRAME_DIV
// S_UPDATE  | update working slot `slot`, one slot per cycle
// S_PUBLISH | copy working bank into snapshot, pulse update_done
// ---------------------------------------------------------------------------
module bounce_scheduler #(
    parameter int N_OBJ      = 4,
    parameter int IDX_W      = 2,
    parameter int Bit_Wight  = 10,
    parameter int Wight      = 640,
    parameter int Height     = 480,
    parameter int Radius     = 150,
    parameter int Line_Width = 3,
    parameter int STEP_X     = 3,
    parameter int STEP_Y     = 1,
    parameter int SPACING    = 16,
    parameter int FRAME_DIV  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 enable,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [Bit_Wight-1:0] rd_x,
    output logic [Bit_Wight-1:0] rd_y,
    output logic                 busy,
    output logic                 update_done,
    output logic                 overrun
);

    localparam int START_CENTR = Radius + Line_Width;
    // One extra bit so p + STEP never wraps before the bound compare.
    localparam int EW   = Bit_Wight + 1;
    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [EW-1:0] LO_E     = EW'(START_CENTR);
    localparam logic [EW-1:0] HI_X_E   = EW'(Wight - START_CENTR);
    localparam logic [EW-1:0] HI_Y_E   = EW'(Height - START_CENTR);
    localparam logic [EW-1:0] STEP_X_E = EW'(STEP_X);
    localparam logic [EW-1:0] STEP_Y_E = EW'(STEP_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_PUBLISH
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     slot;
    logic [FC_W-1:0]      frame_cnt;

    logic [Bit_Wight-1:0] work_x [N_OBJ];
    logic [Bit_Wight-1:0] work_y [N_OBJ];
    logic                 dir_x  [N_OBJ];
    logic                 dir_y  [N_OBJ];
    logic [Bit_Wight-1:0] snap_x [N_OBJ];
    logic [Bit_Wight-1:0] snap_y [N_OBJ];

    logic [Bit_Wight-1:0] nx, ny;
    logic                 ndx, ndy;

    // Returns {new_dir, new_pos}. Reaching a bound clamps to it and flips the
    // direction in the same update, so an object never leaves [LO, HI].
    function automatic logic [EW-1:0] step_axis(
        input logic [Bit_Wight-1:0] p,
        input logic                 dir,
        input logic [EW-1:0]        step,
        input logic [EW-1:0]        hi
    );
        logic [EW-1:0] pe;
        logic [EW-1:0] res;
        logic          nd;
        pe  = {1'b0, p};
        res = pe;
        nd  = dir;
        if (dir) begin
            if (pe + step <= hi) begin
                res = pe + step;
            end else begin
                res = hi;
                nd  = 1'b0;
            end
        end else begin
            if (pe >= LO_E + step) begin
                res = pe - step;
            end else begin
                res = LO_E;
                nd  = 1'b1;
            end
        end
        return {nd, res[Bit_Wight-1:0]};
    endfunction

    // Shared datapath: only the slot currently addressed is evaluated.
    always_comb begin
        {ndx, nx} = step_axis(work_x[slot], dir_x[slot], STEP_X_E, HI_X_E);
        {ndy, ny} = step_axis(work_y[slot], dir_y[slot], STEP_Y_E, HI_Y_E);
    end

    assign overrun = frame_start & busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            slot        <= '0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                work_x[i] <= Bit_Wight'(START_CENTR + i * SPACING);
                work_y[i] <= Bit_Wight'(START_CENTR);
                dir_x[i]  <= 1'b1;
                dir_y[i]  <= 1'b1;
                snap_x[i] <= Bit_Wight'(START_CENTR + i * SPACING);
                snap_y[i] <= Bit_Wight'(START_CENTR);
            end
        end else begin
            update_done <= 1'b0;

            if (int'(rd_idx) < N_OBJ) begin
                rd_x <= snap_x[rd_idx];
                rd_y <= snap_y[rd_idx];
            end else begin
                rd_x <= '0;
                rd_y <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start && enable) begin
                        if (frame_cnt == FC_W'(FRAME_DIV - 1)) begin
                            frame_cnt <= '0;
                            slot      <= '0;
                            busy      <= 1'b1;
                            state     <= S_UPDATE;
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    work_x[slot] <= nx;
                    work_y[slot] <= ny;
                    dir_x[slot]  <= ndx;
                    dir_y[slot]  <= ndy;
                    if (slot == IDX_W'(N_OBJ - 1)) begin
                        update_done <= 1'b1;
                        state       <= S_PUBLISH;
                    end else begin
                        slot <= slot + IDX_W'(1);
                    end
                end
                S_PUBLISH: begin
                    for (int i = 0; i < N_OBJ; i++) begin
                        snap_x[i] <= work_x[i];
                        snap_y[i] <= work_y[i];
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_scheduler.sv
`timescale 1ns/1ps
module tb_bounce_scheduler;

    localparam int N_OBJ = 4;
    localparam int IDX_W = 2;
    localparam int BW    = 10;
    localparam int LO    = 153;
    localparam int HI_X  = 487;
    localparam int HI_Y  = 327;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             enable = 1'b1;
    logic [IDX_W-1:0] rd_idx = '0;
    logic [BW-1:0]    rd_x, rd_y;
    logic             busy, update_done, overrun;

    logic             fs3 = 1'b0;
    logic             en3 = 1'b1;
    logic [IDX_W-1:0] rd_idx3 = '0;
    logic [BW-1:0]    rd_x3, rd_y3;
    logic             busy3, done3, ovr3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int slot;
        int x;
        int y;
    } exp_t;
    exp_t exp_q[$];

    int mx[N_OBJ];
    int my[N_OBJ];
    bit mdx[N_OBJ];
    bit mdy[N_OBJ];

    always #5 clk = ~clk;

    bounce_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    bounce_scheduler #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs3), .enable(en3),
        .rd_idx(rd_idx3), .rd_x(rd_x3), .rd_y(rd_y3),
        .busy(busy3), .update_done(done3), .overrun(ovr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_OBJ; i++) begin
            mx[i] = LO + 16 * i;
            my[i] = LO;
            mdx[i] = 1'b1;
            mdy[i] = 1'b1;
        end
    endfunction

    function automatic void model_pass();
        for (int i = 0; i < N_OBJ; i++) begin
            if (mdx[i]) begin
                if (mx[i] + 3 <= HI_X) mx[i] = mx[i] + 3;
                else begin mx[i] = HI_X; mdx[i] = 1'b0; end
            end else begin
                if (mx[i] >= LO + 3) mx[i] = mx[i] - 3;
                else begin mx[i] = LO; mdx[i] = 1'b1; end
            end
            if (mdy[i]) begin
                if (my[i] + 1 <= HI_Y) my[i] = my[i] + 1;
                else begin my[i] = HI_Y; mdy[i] = 1'b0; end
            end else begin
                if (my[i] >= LO + 1) my[i] = my[i] - 1;
                else begin my[i] = LO; mdy[i] = 1'b1; end
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        for (int i = 0; i < N_OBJ; i++) begin
            e.slot = i;
            e.x = mx[i];
            e.y = my[i];
            exp_q.push_back(e);
        end
    endfunction

    task automatic read_slot(input int idx, output logic [31:0] ox, output logic [31:0] oy);
        @(posedge clk); #1;
        rd_idx = IDX_W'(idx);
        @(posedge clk);
        @(negedge clk);
        ox = 32'(rd_x);
        oy = 32'(rd_y);
    endtask

    task automatic check_snap();
        exp_t e;
        logic [31:0] ox, oy;
        for (int i = 0; i < N_OBJ; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty: observed empty queue expected %0d entries", N_OBJ);
            end else begin
                e = exp_q.pop_front();
                read_slot(e.slot, ox, oy);
                check($sformatf("snap_x[%0d]", e.slot), ox, 32'(e.x));
                check($sformatf("snap_y[%0d]", e.slot), oy, 32'(e.y));
            end
        end
    endtask

    // or_at: cycle offset from T carrying an extra frame_start (0 = none).
    // started: frame_start already high in the current cycle (chained pass).
    // chain: raise frame_start in the first idle cycle after this pass.
    task automatic do_pass(input int or_at, input bit started, input bit chain,
                           input bit do_check, input bit timing);
        if (!started) begin
            @(posedge clk); #1;
            frame_start = 1'b1;
        end
        model_pass();
        if (do_check) push_exp();
        for (int c = 1; c <= N_OBJ + 1; c++) begin
            @(posedge clk); #1;
            frame_start = (c == or_at);
            @(negedge clk);
            if (timing) begin
                check($sformatf("busy_T+%0d", c), 32'(busy), 32'd1);
                check($sformatf("update_done_T+%0d", c), 32'(update_done), 32'(c == N_OBJ + 1));
                check($sformatf("overrun_T+%0d", c), 32'(overrun), 32'(c == or_at));
            end
        end
        @(posedge clk); #1;
        frame_start = chain;
        @(negedge clk);
        if (timing) begin
            check("busy_after_pass", 32'(busy), 32'd0);
            check("update_done_after_pass", 32'(update_done), 32'd0);
        end
        if (do_check && !chain) check_snap();
    endtask

    initial begin
        logic [31:0] ox, oy;
        int init_x[N_OBJ] = '{153, 169, 185, 201};
        int hits[7] = '{0, 0, 1, 0, 0, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_update_done", 32'(update_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_x", 32'(rd_x), 32'd0);
        check("rst_rd_y", 32'(rd_y), 32'd0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N_OBJ; i++) begin
            read_slot(i, ox, oy);
            check($sformatf("init_x[%0d]", i), ox, 32'(init_x[i]));
            check($sformatf("init_y[%0d]", i), oy, 32'd153);
        end
        push_exp();
        check_snap();

        // First pass with full timing checks
        do_pass(0, 1'b0, 1'b0, 1'b1, 1'b1);
        read_slot(0, ox, oy);
        check("pass1_slot0_x", ox, 32'd156);
        check("pass1_slot0_y", oy, 32'd154);
        read_slot(3, ox, oy);
        check("pass1_slot3_x", ox, 32'd204);
        check("pass1_slot3_y", oy, 32'd154);

        // Long run to the bounds
        for (int n = 2; n <= 175; n++) begin
            bit mile;
            mile = (n == 111) || (n == 112) || (n == 113) || (n == 174) || (n == 175);
            do_pass(0, 1'b0, 1'b0, mile, 1'b0);
            if (mile) begin
                read_slot(0, ox, oy);
                if (n == 111) check("pass111_x", ox, 32'd486);
                if (n == 112) check("pass112_x", ox, 32'd487);
                if (n == 113) check("pass113_x", ox, 32'd484);
                if (n == 174) check("pass174_y", oy, 32'd327);
                if (n == 175) check("pass175_y", oy, 32'd327);
            end
        end

        // frame_start during UPDATE: overrun, single pass only
        do_pass(3, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_second_pass", 32'(busy), 32'd0);
        end

        // frame_start in PUBLISH is overrun; first idle cycle is accepted
        do_pass(N_OBJ + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        do_pass(0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a pass
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_update_done", 32'(update_done), 32'd0);
        check("midrst_rd_x", 32'(rd_x), 32'd0);
        check("midrst_rd_y", 32'(rd_y), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        push_exp();
        check_snap();
        do_pass(0, 1'b0, 1'b0, 1'b1, 1'b1);
        read_slot(0, ox, oy);
        check("postrst_slot0_x", ox, 32'd156);
        check("postrst_slot0_y", oy, 32'd154);

        // Frame divider of 3
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            fs3 = 1'b1;
            @(posedge clk); #1;
            fs3 = 1'b0;
            @(negedge clk);
            check($sformatf("div3_start%0d", k + 1), 32'(busy3), 32'(hits[k]));
            repeat (8) @(posedge clk);
        end
        en3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            fs3 = 1'b1;
            @(posedge clk); #1;
            fs3 = 1'b0;
            @(negedge clk);
            check("div3_disabled", 32'(busy3), 32'd0);
            repeat (3) @(posedge clk);
        end
        en3 = 1'b1;
        // Counter held at 1 through the disabled frames: one more start
        // brings it to 2, the next triggers a pass.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            fs3 = 1'b1;
            @(posedge clk); #1;
            fs3 = 1'b0;
            @(negedge clk);
            check($sformatf("div3_resume%0d", k + 1), 32'(busy3), 32'(k == 1));
            if (k == 0) repeat (3) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("div3_update_done", 32'(done3), 32'd1);
        check("div3_overrun", 32'(ovr3), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("div3_slot0_x", 32'(rd_x3), 32'd162);
        check("div3_slot0_y", 32'(rd_y3), 32'd156);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
